push_debounce: RTL and testbench

Upstream input stage for the paddle game. Takes the four raw `PUSH` buttons and produces clean, debounced button state plus one-cycle press pulses on `CLK`. The game logic consumes the pulses directly, so it no longer needs its own per-button edge registers. An optional auto-repeat mode makes a held button keep moving a paddle.

---
 rtl/push_pkg.sv | 25 ++
 rtl/push_debounce_chan.sv | 151 +++++++++++++++
 rtl/push_debounce.sv | 71 +++++++
 tb/tb_push_debounce.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/push_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Contents:
//   push_rpt_e - per-channel auto-repeat state (idle / delay / repeat)
//   *Default   - default values for every push_debounce parameter
//   cnt_width  - bit width of a counter that runs 0..max_count-1 (never below 1)
package push_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } push_rpt_e;

  localparam int unsigned NumButtons           = 4;
  localparam int unsigned TickDivDefault       = 2000;
  localparam int unsigned DebounceTicksDefault = 4;
  localparam int unsigned ActiveLowDefault     = 1;
  localparam int unsigned RepeatDelayDefault   = 150;
  localparam int unsigned RepeatRateDefault    = 50;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/push_debounce_chan.sv
// One debounced button channel.
// Optional feature: define PUSH_REPEAT_EN to add the auto-repeat FSM.
// Ports:
//   clk_i   - system clock
//   rst_i   - asynchronous active-high reset
//   raw_i   - raw button level, asynchronous to clk_i
//   tick_i  - shared one-cycle sample strobe
//   held_o  - debounced pressed state (1 = pressed)
//   press_o - one-cycle pulse per accepted press (and per repeat when enabled)
module push_debounce_chan
  import push_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DebounceTicksDefault,
  parameter int unsigned ACTIVE_LOW     = ActiveLowDefault
`ifdef PUSH_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY   = RepeatDelayDefault,
  parameter int unsigned REPEAT_RATE    = RepeatRateDefault
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  input  logic tick_i,
  output logic held_o,
  output logic press_o
);

  // Raw level of a released button; the synchronizer resets here so leaving
  // reset never looks like a press.
  localparam logic RawReleased = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam int unsigned    DcntW    = cnt_width(DEBOUNCE_TICKS);
  localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_TICKS - 1);

  logic             sync1_q, sync2_q;
  logic             sample;
  logic [DcntW-1:0] dcnt_d, dcnt_q;
  logic             held_d, held_q;
  logic             press_d, press_q;
  logic             differ;
  logic             accept;
  logic             rise;
  logic             fall;

  // Normalize to pressed = 1.
  assign sample = sync2_q ^ RawReleased;
  assign differ = (sample != held_q);
  assign accept = tick_i && differ && (dcnt_q == DcntLast);
  assign rise   = accept && !held_q;
  assign fall   = accept && held_q;

  always_comb begin
    dcnt_d = dcnt_q;
    held_d = held_q;
    if (tick_i) begin
      if (!differ) begin
        dcnt_d = '0;
      end else if (dcnt_q == DcntLast) begin
        held_d = ~held_q;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

`ifdef PUSH_REPEAT_EN
  localparam int unsigned RcntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RcntW   = cnt_width(RcntMax);
  localparam logic [RcntW-1:0] RcntDelayLast = RcntW'(REPEAT_DELAY - 1);
  localparam logic [RcntW-1:0] RcntRateLast  = RcntW'(REPEAT_RATE - 1);

  push_rpt_e        state_d, state_q;
  logic [RcntW-1:0] rcnt_d, rcnt_q;
  logic             rpt_pulse;

  // A falling HELD wins over any repeat due on the same tick.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rpt_pulse = 1'b0;
    if (fall) begin
      state_d = StIdle;
      rcnt_d  = '0;
    end else if (rise) begin
      state_d = StDelay;
      rcnt_d  = '0;
    end else if (tick_i) begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StDelay: begin
          if (rcnt_q == RcntDelayLast) begin
            rpt_pulse = 1'b1;
            state_d   = StRepeat;
            rcnt_d    = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (rcnt_q == RcntRateLast) begin
            rpt_pulse = 1'b1;
            rcnt_d    = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  assign press_d = rise | rpt_pulse;
`else
  assign press_d = rise;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= RawReleased;
      sync2_q <= RawReleased;
      dcnt_q  <= '0;
      held_q  <= 1'b0;
      press_q <= 1'b0;
`ifdef PUSH_REPEAT_EN
      state_q <= StIdle;
      rcnt_q  <= '0;
`endif
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      dcnt_q  <= dcnt_d;
      held_q  <= held_d;
      press_q <= press_d;
`ifdef PUSH_REPEAT_EN
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  assign held_o  = held_q;
  assign press_o = press_q;

endmodule

// File: rtl/push_debounce.sv
// Debounced input stage for the four paddle-game push buttons.
// Optional feature: define PUSH_REPEAT_EN for auto-repeat while a button is held.
// Ports:
//   CLK   - system clock
//   RST   - asynchronous active-high reset
//   PUSH  - raw button levels (4), asynchronous to CLK
//   HELD  - debounced pressed state (4), 1 = pressed
//   PRESS - one-cycle pulse per accepted press / repeat (4)
//   TICK  - one-cycle sample strobe every TICK_DIV cycles
module push_debounce
  import push_pkg::*;
#(
  parameter int unsigned TICK_DIV       = TickDivDefault,
  parameter int unsigned DEBOUNCE_TICKS = DebounceTicksDefault,
  parameter int unsigned ACTIVE_LOW     = ActiveLowDefault,
  parameter int unsigned REPEAT_DELAY   = RepeatDelayDefault,
  parameter int unsigned REPEAT_RATE    = RepeatRateDefault
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NumButtons-1:0] PUSH,
  output logic [NumButtons-1:0] HELD,
  output logic [NumButtons-1:0] PRESS,
  output logic                  TICK
);

  localparam int unsigned      TcntW    = cnt_width(TICK_DIV);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TICK_DIV - 1);

  logic [TcntW-1:0] tcnt_d, tcnt_q;
  logic             tick;

  assign tick = (tcnt_q == TcntLast);

  always_comb begin
    tcnt_d = tcnt_q + 1'b1;
    if (tick) begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign TICK = tick;

  for (genvar i = 0; i < NumButtons; i++) begin : g_chan
    push_debounce_chan #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .ACTIVE_LOW     (ACTIVE_LOW)
`ifdef PUSH_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
`endif
    ) u_chan (
      .clk_i   (CLK),
      .rst_i   (RST),
      .raw_i   (PUSH[i]),
      .tick_i  (tick),
      .held_o  (HELD[i]),
      .press_o (PRESS[i])
    );
  end

endmodule

// File: tb/tb_push_debounce.sv
// Directed self-checking bench for push_debounce.
// Configuration: TICK_DIV=4, DEBOUNCE_TICKS=3, ACTIVE_LOW=1, REPEAT_DELAY=5, REPEAT_RATE=2.
// Stimulus is driven and outputs sampled on the falling clock edge.
module tb_push_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] push;
  logic [3:0] held;
  logic [3:0] press;
  logic       tick;

  push_debounce #(
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (5),
    .REPEAT_RATE    (2)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .PUSH  (push),
    .HELD  (held),
    .PRESS (press),
    .TICK  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation statistics, cleared at the start of each measured window.
  int         cyc;
  int         press_cnt[4];
  int         press_first[4];
  int         held_rise[4];
  int         held_fall[4];
  int         tick_cnt;
  int         tick_first;
  logic [3:0] held_prev;
  int         press_q2[$];

  task automatic clear_stats();
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      press_cnt[i]   = 0;
      press_first[i] = -1;
      held_rise[i]   = -1;
      held_fall[i]   = -1;
    end
    tick_cnt   = 0;
    tick_first = -1;
    held_prev  = held;
    press_q2.delete();
  endtask

  // Advance one cycle and record what the outputs did.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (press[i] === 1'b1) begin
        press_cnt[i]++;
        if (press_first[i] < 0) press_first[i] = cyc;
      end
      if (held[i] === 1'b1 && held_prev[i] === 1'b0) held_rise[i] = cyc;
      if (held[i] === 1'b0 && held_prev[i] === 1'b1) held_fall[i] = cyc;
    end
    held_prev = held;
    if (tick === 1'b1) begin
      tick_cnt++;
      if (tick_first < 0) tick_first = cyc;
    end
    if (press[2] === 1'b1) press_q2.push_back(cyc);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Align so the next rising edge is the one that consumes TICK.
  task automatic wait_tick_phase();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_phase: tick=%b after %0d cycles, required 1 within 4", tick, n);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    push = 4'hF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (held !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_held: got %h required 0", held);
    end
    n_checks++;
    if (press !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_press: got %h required 0", press);
    end
    n_checks++;
    if (tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tick: got %b required 0", tick);
    end
    rst = 1'b0;
    clear_stats();
    steps(16);
    n_checks++;
    if (tick_cnt !== 4 || tick_first !== 3) begin
      n_fail++;
      $display("FAIL reset_tick_rate: count %0d first %0d, required 4 and 3", tick_cnt, tick_first);
    end
    n_checks++;
    if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] !== 0 || held !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_exit_quiet: presses %0d held %h, required 0 and 0",
               press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], held);
    end
  endtask

  task automatic test_clean_press();
    wait_tick_phase();
    clear_stats();
    push[0] = 1'b0;
    steps(20);
    // 2 sync edges, then acceptance on the 3rd tick: 13 edges after the change.
    n_checks++;
    if (held_rise[0] !== 13) begin
      n_fail++;
      $display("FAIL clean_held_rise: cycle %0d required 13", held_rise[0]);
    end
    n_checks++;
    if (press_cnt[0] !== 1 || press_first[0] !== 13) begin
      n_fail++;
      $display("FAIL clean_press_pulse: count %0d at %0d, required 1 at 13",
               press_cnt[0], press_first[0]);
    end
    n_checks++;
    if (held !== 4'h1) begin
      n_fail++;
      $display("FAIL clean_held_state: got %h required 1", held);
    end
    wait_tick_phase();
    clear_stats();
    push[0] = 1'b1;
    steps(20);
    n_checks++;
    if (held_fall[0] !== 13 || held !== 4'h0) begin
      n_fail++;
      $display("FAIL release_held_fall: cycle %0d held %h, required 13 and 0", held_fall[0], held);
    end
    n_checks++;
    if (press_cnt[0] !== 0) begin
      n_fail++;
      $display("FAIL release_no_pulse: got %0d pulses required 0", press_cnt[0]);
    end
  endtask

  task automatic test_bounce();
    wait_tick_phase();
    clear_stats();
    for (int k = 0; k < 8; k++) begin
      push[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
      steps(5);
    end
    n_checks++;
    if (press_cnt[1] !== 0 || held[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_reject: pulses %0d held %b, required 0 and 0", press_cnt[1], held[1]);
    end
    push[1] = 1'b0;
    steps(20);
    n_checks++;
    if (press_cnt[1] !== 1 || held[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_settle: pulses %0d held %b, required 1 and 1", press_cnt[1], held[1]);
    end
    push[1] = 1'b1;
    steps(20);
    n_checks++;
    if (held !== 4'h0) begin
      n_fail++;
      $display("FAIL bounce_release: held %h required 0", held);
    end
  endtask

  task automatic test_simultaneous();
    wait_tick_phase();
    clear_stats();
    push = 4'h0;
    steps(20);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (press_cnt[i] !== 1 || press_first[i] !== 13) begin
        n_fail++;
        $display("FAIL simul_press_ch%0d: count %0d at %0d, required 1 at 13",
                 i, press_cnt[i], press_first[i]);
      end
    end
    n_checks++;
    if (held !== 4'hF) begin
      n_fail++;
      $display("FAIL simul_held: got %h required f", held);
    end
    push = 4'hF;
    steps(20);
    n_checks++;
    if (held !== 4'h0) begin
      n_fail++;
      $display("FAIL simul_release: got %h required 0", held);
    end
  endtask

  task automatic test_reset_mid_debounce();
    wait_tick_phase();
    clear_stats();
    push[3] = 1'b0;
    steps(9);  // two differing ticks consumed, one short of acceptance
    rst = 1'b1;
    steps(2);
    n_checks++;
    if (held !== 4'h0 || press !== 4'h0) begin
      n_fail++;
      $display("FAIL midreset_cleared: held %h press %h, required 0 and 0", held, press);
    end
    rst = 1'b0;
    clear_stats();
    steps(20);
    // Sync refills in 2 edges, ticks consumed on edges 4, 8, 12.
    n_checks++;
    if (held_rise[3] !== 12) begin
      n_fail++;
      $display("FAIL midreset_held_rise: cycle %0d required 12", held_rise[3]);
    end
    n_checks++;
    if (press_cnt[3] !== 1 || press_first[3] !== 12) begin
      n_fail++;
      $display("FAIL midreset_press: count %0d at %0d, required 1 at 12",
               press_cnt[3], press_first[3]);
    end
    push[3] = 1'b1;
    steps(20);
    n_checks++;
    if (held !== 4'h0) begin
      n_fail++;
      $display("FAIL midreset_release: got %h required 0", held);
    end
  endtask

`ifdef PUSH_REPEAT_EN
  task automatic test_repeat();
    int exp_q[$];
    int fall_cyc;
    int late;
    wait_tick_phase();
    clear_stats();
    push[2] = 1'b0;
    steps(160);
    // Acceptance at 13, first repeat 5 ticks (20 cycles) later, then every 8 cycles.
    exp_q.push_back(13);
    for (int t = 33; t <= 160; t += 8) exp_q.push_back(t);
    n_checks++;
    if (press_q2.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d pulses required %0d", press_q2.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (press_q2[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL repeat_pulse_%0d: cycle %0d required %0d", i, press_q2[i], exp_q[i]);
        end
      end
    end
    wait_tick_phase();
    clear_stats();
    push[2] = 1'b1;
    steps(30);
    fall_cyc = held_fall[2];
    late = 0;
    for (int i = 0; i < press_q2.size(); i++) begin
      if (fall_cyc < 0 || press_q2[i] >= fall_cyc) late++;
    end
    n_checks++;
    if (fall_cyc !== 13 || late !== 0) begin
      n_fail++;
      $display("FAIL repeat_stop: fall %0d pulses after fall %0d, required 13 and 0",
               fall_cyc, late);
    end
  endtask
`else
  task automatic test_no_repeat();
    wait_tick_phase();
    clear_stats();
    push[2] = 1'b0;
    steps(160);
    n_checks++;
    if (press_cnt[2] !== 1 || press_first[2] !== 13) begin
      n_fail++;
      $display("FAIL hold_single_press: count %0d at %0d, required 1 at 13",
               press_cnt[2], press_first[2]);
    end
    push[2] = 1'b1;
    steps(20);
    n_checks++;
    if (held !== 4'h0 || press_cnt[2] !== 1) begin
      n_fail++;
      $display("FAIL hold_release: held %h count %0d, required 0 and 1", held, press_cnt[2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
`ifdef PUSH_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
